// File: rtl/alu_mem_pkg.sv
// Shared widths and FSM encoding for the memory-to-memory ALU sequencer.
package alu_mem_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    CAP_B = 3'd3,
    EXEC  = 3'd4,
    WR    = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/alu_mem_sequencer.sv
// Runs mem[dst] = ALU(mem[src_a], mem[src_b], op) as a fixed 6-cycle walk
// through read A, read B, capture, execute, write and done.
module alu_mem_sequencer
  import alu_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [OP_W-1:0]   op,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_WE,
  output logic              mem_RE,
  output logic              mem_Enable,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] alu_ain,
  output logic [DATA_W-1:0] alu_bin,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_aluout
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] src_a_r, src_b_r, dst_r;
  logic [OP_W-1:0]   op_r;
  logic [DATA_W-1:0] opa_r, opb_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      src_a_r <= '0;
      src_b_r <= '0;
      dst_r   <= '0;
      op_r    <= '0;
      opa_r   <= '0;
      opb_r   <= '0;
      result  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          src_a_r <= src_a;
          src_b_r <= src_b;
          dst_r   <= dst;
          op_r    <= op;
        end
        // MEM data lags its read strobe by one cycle, so A lands during RD_B
        RD_B:  opa_r  <= mem_data_out;
        CAP_B: opb_r  <= mem_data_out;
        EXEC:  result <= alu_aluout;
        default: ;
      endcase
    end
  end

  // Strobes decode purely from registered state so reset drops them at once
  always_comb begin
    state_nx    = state;
    mem_address = '0;
    mem_RE      = 1'b0;
    mem_WE      = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = RD_A;
      RD_A:  begin mem_address = src_a_r; mem_RE = 1'b1; state_nx = RD_B; end
      RD_B:  begin mem_address = src_b_r; mem_RE = 1'b1; state_nx = CAP_B; end
      CAP_B: state_nx = EXEC;
      EXEC:  state_nx = WR;
      WR:    begin mem_address = dst_r; mem_WE = 1'b1; state_nx = DONE; end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_Enable  = mem_RE | mem_WE;
  assign mem_data_in = result;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign alu_ain     = opa_r;
  assign alu_bin     = opb_r;
  assign alu_ctrl    = op_r;

endmodule

// File: tb/tb_alu_mem_sequencer.sv
// Sequencer with behavioural MEM and ALU, checked against a shadow memory model.
module tb_alu_mem_sequencer;

  logic       clk, rst_n, start;
  logic [8:0] src_a, src_b, dst;
  logic [3:0] op;
  logic       busy, done;
  logic [7:0] result;
  logic [8:0] mem_address;
  logic [7:0] mem_data_in, mem_data_out;
  logic       mem_WE, mem_RE, mem_Enable;
  logic [7:0] alu_ain, alu_bin, alu_aluout;
  logic [3:0] alu_ctrl;

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  alu_mem_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_a(src_a), .src_b(src_b), .dst(dst), .op(op),
    .busy(busy), .done(done), .result(result),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_WE(mem_WE), .mem_RE(mem_RE), .mem_Enable(mem_Enable),
    .mem_data_out(mem_data_out),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_ctrl(alu_ctrl),
    .alu_aluout(alu_aluout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] o);
    case (o)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return ~a;
      4'h6: return a << 1;
      4'h7: return a >> 1;
      4'h8: return a + 8'd1;
      4'h9: return a - 8'd1;
      default: return b;
    endcase
  endfunction

  assign alu_aluout = alu_f(alu_ain, alu_bin, alu_ctrl);

  // MEM stand-in with a backdoor preload port
  logic [7:0] mem [512];
  logic [7:0] ref_mem [512];
  logic       pl_en;
  logic [8:0] pl_addr;
  logic [7:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_Enable && mem_WE) mem[mem_address] <= mem_data_in;
    if (mem_Enable && mem_RE) mem_data_out <= mem[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    chk("re_we_exclusive", {31'd0, mem_RE & mem_WE}, 32'd0);
    chk("enable_eq_re_or_we", {31'd0, mem_Enable}, {31'd0, mem_RE | mem_WE});
  end

  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Full command with exact latency check; called at a negedge while idle
  task automatic run_cmd(input string tag, input logic [8:0] a, input logic [8:0] b,
                         input logic [8:0] d, input logic [3:0] o);
    logic [7:0] exp;
    exp = alu_f(ref_mem[a], ref_mem[b], o);
    src_a = a; src_b = b; dst = d; op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int k = 1; k < 6; k++) begin
      chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    chk({tag, "_done_at_6"}, {31'd0, done}, 32'd1);
    chk({tag, "_result"}, {24'd0, result}, {24'd0, exp});
    chk({tag, "_mem_dst"}, {24'd0, mem[d]}, {24'd0, exp});
    ref_mem[d] = exp;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [8:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 9'($urandom_range(0, 15));
    return 9'($urandom_range(0, 511));
  endfunction

  initial begin
    logic [7:0] exp1, keep;
    int ndone, cnt;
    rst_n = 1'b1; start = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    src_a = '0; src_b = '0; dst = '0; op = '0;

    // Reset asserted mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we", {31'd0, mem_WE}, 32'd0);
    chk("rst_re", {31'd0, mem_RE}, 32'd0);
    chk("rst_en", {31'd0, mem_Enable}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_addr", {23'd0, mem_address}, 32'd0);
    chk("rst_alu_ain", {24'd0, alu_ain}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 512; i++) preload(9'(i), 8'($urandom));

    // Basic op
    preload(9'h005, 8'h12);
    preload(9'h1A0, 8'h34);
    run_cmd("basic", 9'h005, 9'h1A0, 9'h0FF, 4'h3);

    // Full aliasing: reads must see the pre-write value
    preload(9'h010, 8'h7F);
    run_cmd("alias", 9'h010, 9'h010, 9'h010, 4'h0);
    chk("alias_value", {24'd0, mem[9'h010]}, 32'h000000FE);

    // Start while busy is ignored and inputs are not re-sampled
    preload(9'h020, 8'h0A);
    preload(9'h021, 8'h03);
    preload(9'h1F0, 8'h55);
    exp1 = alu_f(8'h0A, 8'h03, 4'h1);
    src_a = 9'h020; src_b = 9'h021; dst = 9'h030; op = 4'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k < 16; k++) begin
      if (k == 3) begin
        src_a = 9'h100; src_b = 9'h101; dst = 9'h1F0; op = 4'h4; start = 1'b1;
      end else start = 1'b0;
      if (done) ndone++;
      @(negedge clk);
    end
    chk("busy_start_done_count", 32'(ndone), 32'd1);
    chk("busy_start_dst1", {24'd0, mem[9'h030]}, {24'd0, exp1});
    chk("busy_start_dst2_untouched", {24'd0, mem[9'h1F0]}, 32'h00000055);
    ref_mem[9'h030] = exp1;

    // Reset during RD_A drops strobes asynchronously
    src_a = 9'h040; src_b = 9'h041; dst = 9'h042; op = 4'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rda_re_before_rst", {31'd0, mem_RE}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rda_rst_re", {31'd0, mem_RE}, 32'd0);
    chk("rda_rst_en", {31'd0, mem_Enable}, 32'd0);
    chk("rda_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during EXEC: no write, no done
    keep = ref_mem[9'h052];
    src_a = 9'h050; src_b = 9'h051; dst = 9'h052; op = 4'h4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("exec_rst_busy", {31'd0, busy}, 32'd0);
    chk("exec_rst_result", {24'd0, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("exec_rst_no_done", 32'(ndone), 32'd0);
    chk("exec_rst_no_write", {24'd0, mem[9'h052]}, {24'd0, keep});

    // Random soak with start held high
    src_a = rnd_addr(); src_b = rnd_addr(); dst = rnd_addr(); op = 4'($urandom_range(0, 15));
    exp1 = alu_f(ref_mem[src_a], ref_mem[src_b], op);
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!done && cnt < 20);
      chk("soak_done_seen", {31'd0, done}, 32'd1);
      chk("soak_spacing", 32'(cnt), (i == 0) ? 32'd6 : 32'd7);
      chk("soak_result", {24'd0, result}, {24'd0, exp1});
      chk("soak_mem_dst", {24'd0, mem[dst]}, {24'd0, exp1});
      ref_mem[dst] = exp1;
      if (i == 999) start = 1'b0;
      src_a = rnd_addr(); src_b = rnd_addr(); dst = rnd_addr(); op = 4'($urandom_range(0, 15));
      exp1 = alu_f(ref_mem[src_a], ref_mem[src_b], op);
    end
    repeat (3) @(negedge clk);
    chk("soak_end_idle", {31'd0, busy}, 32'd0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mem_sequencer.md
Name: alu_mem_sequencer

Overview:
- Controller that runs one memory-to-memory ALU operation per command: mem[dst] = ALU(mem[src_a], mem[src_b], op).
- Sits between a command source and the existing MEM (9-bit address, 8-bit data, synchronous) and alu8bit (combinational) blocks.
- Drives all MEM and ALU control and data inputs. Reports busy and done to the requester.

Parameters:
- ADDR_W, 9, MEM address width
- DATA_W, 8, data and ALU operand width
- OP_W, 4, ALU ctrl width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- src_a  in  ADDR_W  address of operand A
- src_b  in  ADDR_W  address of operand B
- dst  in  ADDR_W  result address
- op  in  OP_W  ALU ctrl code
- busy  out  1  high while a command is in flight
- done  out  1  one-cycle pulse when the write has completed
- result  out  DATA_W  last ALU result; held until the next EXEC
- mem_address  out  ADDR_W  to MEM address
- mem_data_in  out  DATA_W  to MEM data_in
- mem_WE  out  1  to MEM WE
- mem_RE  out  1  to MEM RE
- mem_Enable  out  1  to MEM Enable
- mem_data_out  in  DATA_W  from MEM data_out
- alu_ain  out  DATA_W  to ALU ain
- alu_bin  out  DATA_W  to ALU bin
- alu_ctrl  out  OP_W  to ALU ctrl
- alu_aluout  in  DATA_W  from ALU aluout

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy, done, mem_WE, mem_RE, mem_Enable = 0; result, operand regs, command regs, mem_address, mem_data_in = 0.
- MEM contract:
  - Read: Enable&RE at posedge N makes data_out = mem[address] valid after posedge N.
  - Write: Enable&WE at posedge N writes data_in.
- FSM states, one per cycle, no stalls:
  - IDLE: if start=1, capture src_a/src_b/dst/op into regs; go to RD_A.
  - RD_A: address=src_a_r, RE=1, Enable=1; go to RD_B.
  - RD_B: address=src_b_r, RE=1, Enable=1; latch opa_r <= mem_data_out at cycle end; go to CAP_B.
  - CAP_B: strobes low; latch opb_r <= mem_data_out; go to EXEC.
  - EXEC: ALU sees opa_r/opb_r/op_r; result <= alu_aluout; go to WR.
  - WR: address=dst_r, data_in=result, WE=1, Enable=1; go to DONE.
  - DONE: done=1 for exactly one cycle; go to IDLE.
- Latency: done is high in the 6th cycle after the cycle in which start was sampled.
- busy=1 in every state except IDLE.
- alu_ain/alu_bin/alu_ctrl are driven continuously from opa_r/opb_r/op_r.
- mem_data_in is driven from result.
- mem_address is 0 in IDLE, CAP_B, EXEC and DONE.
- Invariants:
  - mem_RE and mem_WE are never both high.
  - mem_Enable = mem_RE | mem_WE.
  - All MEM outputs are registered or decoded from registered state; they are glitch-free at posedge.
- Boundary cases:
  - start while busy: ignored; no queuing; the command inputs are not re-sampled.
  - start held high: a new command is accepted in the first IDLE cycle after DONE, so there is a 1-cycle gap between commands.
  - src_a == src_b: legal; both reads return the same value.
  - dst == src_a or dst == src_b: legal; the write occurs after both reads complete.
  - rst_n low mid-command: immediate return to IDLE, strobes dropped asynchronously, no partial write, done not pulsed.
  - Address wrap: none; addresses are used as given (0..511).

Decomposition:
- Shared package (alu_mem_pkg): ADDR_W/DATA_W/OP_W defaults and the state encoding localparams (IDLE=0 .. DONE=6, 3 bits).
- Single module; no sub-module needed. Bench instantiates MEM, alu8bit and the sequencer together.

Test Plan:
- Reset: assert rst_n=0 at a mid-cycle time -> busy, done, mem_WE, mem_RE, mem_Enable all 0 immediately; state IDLE.
- Basic op: preload mem[9'h005]=8'h12, mem[9'h1A0]=8'h34; start with op=4'h3, dst=9'h0FF.
  - done pulses exactly 6 posedges after the start sample.
  - mem[9'h0FF] == result == alu8bit(8'h12, 8'h34, 4'h3).
- Aliasing: src_a=src_b=dst=9'h010, mem=8'h7F, op=4'h0 -> mem[9'h010] == alu8bit(8'h7F, 8'h7F, 4'h0) after done; the reads see the old value.
- Start during busy: second start pulse with different addresses at cycle 3 -> ignored; only one done pulse; only the first dst is written.
- Reset mid-command: rst_n low during EXEC -> no write to dst (mem[dst] unchanged), no done pulse.
- Random soak: 1000 random commands with start held high. Each result is checked against an ALU model. A protocol monitor checks that RE&WE is never 1 and Enable == RE|WE every cycle.
